// File: rtl/dword_tx_serializer_pkg.sv
// Shared constants and FSM encoding for the debug-word UART serializer.
package dword_tx_serializer_pkg;

  localparam int BYTE              = 8;
  localparam int DWORD             = 32;
  localparam int NB_BYTES_PER_WORD = DWORD / BYTE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_WAIT  = 2'b10
  } state_e;

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with occupancy count; pushes while full and pops while empty are ignored.
module sync_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign o_full  = (count_q == (PTR_W+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];

  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  // NOTE: every signal gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count and pointers alone decide what is valid.
  always_ff @(posedge i_clock) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/dword_tx_serializer.sv
// Buffers debug words and feeds them to the UART one byte per tx_start, pacing on tx_done.
module dword_tx_serializer
  import dword_tx_serializer_pkg::*;
#(
  parameter int DWORD      = dword_tx_serializer_pkg::DWORD,
  parameter int BYTE       = dword_tx_serializer_pkg::BYTE,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [DWORD-1:0]            i_word_data,
  input  logic                        i_word_valid,
  output logic                        o_word_ready,
  input  logic                        i_tx_done,
  output logic [BYTE-1:0]             o_tx_data,
  output logic                        o_tx_start,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
  output logic                        o_overflow
);

  localparam int NB_BYTES = DWORD / BYTE;
  localparam int CNT_W    = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NB_BYTES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DWORD-1:0] shreg_q, shreg_d;
  logic             overflow_q, overflow_d;

  logic [DWORD-1:0] fifo_rdata;
  logic             fifo_full, fifo_empty, fifo_pop;

  sync_word_fifo #(
    .WIDTH (DWORD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (i_word_valid),
    .i_data  (i_word_data),
    .i_pop   (fifo_pop),
    .o_data  (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (o_fifo_count)
  );

  assign o_word_ready = !fifo_full;
  assign o_busy       = !fifo_empty || (state_q != ST_IDLE);
  assign o_overflow   = overflow_q;
  assign overflow_d   = overflow_q || (i_word_valid && fifo_full);

  // The current byte always sits at the outgoing end of the shift register.
  assign o_tx_data = MSB_FIRST ? shreg_q[DWORD-1 -: BYTE] : shreg_q[BYTE-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    fifo_pop   = 1'b0;
    o_tx_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          cnt_d    = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        o_tx_start = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_tx_done) begin
          if (cnt_q != LAST_BYTE) begin
            shreg_d = MSB_FIRST ? (shreg_q << BYTE) : (shreg_q >> BYTE);
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_START;
          end else if (!fifo_empty) begin
            // Reload straight from WAIT so consecutive words have no idle gap.
            fifo_pop = 1'b1;
            shreg_d  = fifo_rdata;
            cnt_d    = '0;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_dword_tx_serializer.sv
// Drives an LSB-first and an MSB-first serializer with identical stimulus and checks both against a queue model.
module tb_dword_tx_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] word_data = '0;
  logic        word_valid = 1'b0;
  logic        tx_done = 1'b0;

  logic       ready0, ready1, start0, start1, busy0, busy1, ovf0, ovf1;
  logic [7:0] data0, data1;
  logic [2:0] cnt0, cnt1;

  always #5 clk = ~clk;

  dword_tx_serializer #(.DWORD(32), .BYTE(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b0)) u_dut_lsb (
    .i_clock(clk), .i_reset(rst), .i_word_data(word_data), .i_word_valid(word_valid),
    .o_word_ready(ready0), .i_tx_done(tx_done), .o_tx_data(data0), .o_tx_start(start0),
    .o_busy(busy0), .o_fifo_count(cnt0), .o_overflow(ovf0)
  );

  dword_tx_serializer #(.DWORD(32), .BYTE(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b1)) u_dut_msb (
    .i_clock(clk), .i_reset(rst), .i_word_data(word_data), .i_word_valid(word_valid),
    .o_word_ready(ready1), .i_tx_done(tx_done), .o_tx_data(data1), .o_tx_start(start1),
    .o_busy(busy1), .o_fifo_count(cnt1), .o_overflow(ovf1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: words waiting, word in flight, bytes already sent, start pending / awaiting done.
  logic [31:0] m_fifo[$];
  logic [31:0] m_word;
  int          m_idx;
  bit          m_sp, m_w, m_ovf;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int idx, input bit msb);
    int sh;
    sh = msb ? 8 * (3 - idx) : 8 * idx;
    return 8'((w >> sh) & 32'hFF);
  endfunction

  function automatic bit m_busy();
    return (m_fifo.size() > 0) || m_sp || m_w;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_word = '0;
    m_idx  = 0;
    m_sp   = 1'b0;
    m_w    = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [31:0] d, input bit t);
    int fsz;
    bit pop, sp_n, w_n;
    fsz  = m_fifo.size();
    pop  = 1'b0;
    sp_n = m_sp;
    w_n  = m_w;
    if (m_sp) begin
      sp_n = 1'b0;
      w_n  = 1'b1;
    end else if (m_w) begin
      if (t) begin
        if (m_idx < 3) begin
          m_idx++;
          sp_n = 1'b1;
          w_n  = 1'b0;
        end else if (fsz > 0) begin
          pop = 1'b1;
        end else begin
          w_n = 1'b0;
        end
      end
    end else if (fsz > 0) begin
      pop = 1'b1;
    end
    if (pop) begin
      m_word = m_fifo.pop_front();
      m_idx  = 0;
      sp_n   = 1'b1;
      w_n    = 1'b0;
    end
    if (v) begin
      if (fsz < 4) m_fifo.push_back(d);
      else         m_ovf = 1'b1;
    end
    m_sp = sp_n;
    m_w  = w_n;
  endtask

  task automatic compare_all();
    check("start_lsb", start0, m_sp);
    check("start_msb", start1, m_sp);
    check("data_lsb", data0, byte_of(m_word, m_idx, 1'b0));
    check("data_msb", data1, byte_of(m_word, m_idx, 1'b1));
    check("busy_lsb", busy0, m_busy());
    check("busy_msb", busy1, m_busy());
    check("count", cnt0, m_fifo.size());
    check("ready", ready0, m_fifo.size() < 4);
    check("overflow", ovf0, m_ovf);
    check("overflow_msb", ovf1, m_ovf);
  endtask

  // Stimulus controls and UART responder state.
  bit          v_req = 1'b0;
  logic [31:0] d_req = '0;
  bit          force_done = 1'b0;
  bit          stall = 1'b0;
  int          gap = 10;
  int          uart_cnt = 0;
  int          cyc = 0;
  logic [7:0]  seq0[$];
  logic [7:0]  seq1[$];
  int          start_cyc[$];

  task automatic cycle();
    @(negedge clk);
    word_valid = v_req;
    word_data  = d_req;
    tx_done    = force_done;
    if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0 && !stall) tx_done = 1'b1;
    end
    @(posedge clk);
    model_edge(word_valid, word_data, tx_done);
    #1;
    compare_all();
    if (m_sp) uart_cnt = gap;
    if (start0) begin
      seq0.push_back(data0);
      seq1.push_back(data1);
      start_cyc.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic push_word(input logic [31:0] w);
    v_req = 1'b1;
    d_req = w;
    cycle();
    v_req = 1'b0;
  endtask

  task automatic run_until_idle(input int max);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (m_busy() && n < max);
    check("drain_in_time", n < max, 1);
  endtask

  task automatic clear_log();
    seq0.delete();
    seq1.delete();
    start_cyc.delete();
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] q[$], input logic [31:0] e);
    check({tag, "_n"}, q.size(), 4);
    for (int i = 0; i < q.size() && i < 4; i++) check(tag, q[i], e[31-8*i -: 8]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst        = 1'b1;
    word_valid = 1'b0;
    tx_done    = 1'b0;
    v_req      = 1'b0;
    force_done = 1'b0;
    uart_cnt   = 0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int inj;
    model_reset();
    do_reset();

    // LSB-first and MSB-first byte order on a single word, slow UART.
    clear_log();
    gap = 10;
    push_word(32'h11223344);
    run_until_idle(200);
    check_bytes("t1_lsb", seq0, 32'h44332211);
    check_bytes("t1_msb", seq1, 32'h11223344);
    check("t1_busy_end", busy0, 0);

    clear_log();
    push_word(32'hDEADBEEF);
    run_until_idle(200);
    check_bytes("t2_msb", seq1, 32'hDEADBEEF);
    check_bytes("t2_lsb", seq0, 32'hEFBEADDE);

    // UART stalled on an in-flight word: four more fit, the fifth is dropped.
    clear_log();
    stall = 1'b1;
    gap   = 2;
    push_word(32'hA0A1A2A3);
    repeat (4) cycle();
    v_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      d_req = i;
      cycle();
    end
    v_req = 1'b0;
    check("t3_ready", ready0, 0);
    check("t3_count", cnt0, 4);
    check("t3_ovf", ovf0, 1);
    stall    = 1'b0;
    uart_cnt = 2;
    run_until_idle(400);
    check("t3_bytes", seq0.size(), 20);
    if (seq0.size() >= 20) check("t3_last_word", {seq0[16], seq0[17], seq0[18], seq0[19]}, 32'h04000000);

    // Two queued words with immediate done ticks: starts stay evenly spaced across the boundary.
    clear_log();
    gap = 2;
    push_word(32'h10203040);
    push_word(32'h50607080);
    run_until_idle(200);
    check("t4_starts", start_cyc.size(), 8);
    for (int i = 1; i < start_cyc.size(); i++) check("t4_spacing", start_cyc[i] - start_cyc[i-1], 2);

    // Stale done ticks in IDLE and in START must not advance the byte.
    clear_log();
    gap = 10;
    force_done = 1'b1;
    cycle();
    force_done = 1'b0;
    push_word(32'h01020304);
    inj = 0;
    for (int n = 0; n < 200 && m_busy(); n++) begin
      cycle();
      force_done = m_sp && (inj < 2);
      if (force_done) inj++;
    end
    force_done = 1'b0;
    check_bytes("t5_lsb", seq0, 32'h04030201);

    // Reset in the middle of a word.
    clear_log();
    check("t6_ovf_before", ovf0, 1);
    push_word(32'hCAFEF00D);
    for (int n = 0; n < 100 && seq0.size() < 2; n++) cycle();
    do_reset();
    check("t6_ovf_after", ovf0, 0);
    check("t6_count_after", cnt0, 0);
    repeat (30) cycle();
    check("t6_no_more_bytes", seq0.size(), 2);

    // Randomised traffic with noisy done ticks and variable UART speed.
    for (int n = 0; n < 600; n++) begin
      v_req      = ($urandom % 4) == 0;
      d_req      = $urandom;
      force_done = ($urandom % 16) == 0;
      gap        = 2 + int'($urandom % 5);
      cycle();
    end
    v_req      = 1'b0;
    force_done = 1'b0;
    run_until_idle(500);
    check("final_busy", busy0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
